// File: rtl/ppu_pkg.sv
// Shared PPU definitions: the OAM DMA state encoding and fixed transfer constants.
package ppu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam int          OAM_DMA_LEN  = 256;
  localparam logic [15:0] DMA_REG_ADDR = 16'h4014;

endpackage

// File: rtl/ppu_oam_dma.sv
// Sprite OAM DMA: copies one 256-byte CPU page into primary OAM as read/write
// pairs aligned to the CPU phase bit, holding the CPU halted for the whole copy.
module ppu_oam_dma
  import ppu_pkg::*;
#(
  parameter int DMA_LEN = OAM_DMA_LEN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_we,
  input  logic [7:0]  reg_data,
  input  logic [7:0]  oam_base,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] dma_addr,
  output logic        dma_rd,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data,
  output logic        oam_we,
  output logic        cpu_halt,
  output logic        busy
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  dma_state_t state_q, state_d;
  logic       ph_q;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] page_q, page_d;
  logic [7:0] base_q, base_d;

  // State register. A plain synchronous reset is enough here: there is no
  // storage array, only a handful of flops.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; combinational blocks use blocking (=).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ph_q    <= 1'b0;
      cnt_q   <= 8'd0;
      page_q  <= 8'd0;
      base_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ph_q    <= ~ph_q;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      base_q  <= base_d;
    end
  end

  // Next-state and datapath update.
  // NOTE: every signal gets a default at the top so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    page_d  = page_q;
    base_d  = base_q;
    unique case (state_q)
      IDLE: begin
        if (reg_we) begin
          page_d  = reg_data;
          base_d  = oam_base;
          cnt_d   = 8'd0;
          state_d = HALT;
        end
      end
      // ph flips at this edge, so ph_q=1 now means READ lands on ph=0.
      HALT:  state_d = ph_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ:  state_d = WRITE;
      WRITE: begin
        if (cnt_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode only the registered state; write data passes straight
  // from the bus, as the read issued last cycle returns it now.
  always_comb begin
    dma_addr = 16'h0000;
    dma_rd   = 1'b0;
    oam_addr = 8'h00;
    oam_data = 8'h00;
    oam_we   = 1'b0;
    cpu_halt = (state_q != IDLE);
    busy     = (state_q != IDLE);
    case (state_q)
      READ: begin
        dma_addr = {page_q, cnt_q};
        dma_rd   = 1'b1;
      end
      WRITE: begin
        oam_addr = base_q + cnt_q;
        oam_data = mem_data_in;
        oam_we   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ppu_oam_dma.sv
// Randomized bench for ppu_oam_dma: a CPU memory model answers reads and the
// expected OAM image, addresses and halt lengths come from the transfer rules.
module tb_ppu_oam_dma;

  logic        clk;
  logic        reset;
  logic        reg_we;
  logic [7:0]  reg_data;
  logic [7:0]  oam_base;
  logic [7:0]  mem_data_in;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        oam_we;
  logic        cpu_halt;
  logic        busy;

  ppu_oam_dma dut (
    .clk         (clk),
    .reset       (reset),
    .reg_we      (reg_we),
    .reg_data    (reg_data),
    .oam_base    (oam_base),
    .mem_data_in (mem_data_in),
    .dma_addr    (dma_addr),
    .dma_rd      (dma_rd),
    .oam_addr    (oam_addr),
    .oam_data    (oam_data),
    .oam_we      (oam_we),
    .cpu_halt    (cpu_halt),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem     [0:65535];
  logic [7:0] oam_obs [0:255];
  bit         ph_m;
  int         checks = 0;
  int         errors = 0;

  logic [15:0] first_addr;
  logic [15:0] last_addr;
  logic [7:0]  last_waddr;

  // Reference phase: held at 0 in reset, flips on every other edge.
  always @(posedge clk) ph_m <= reset ? 1'b0 : ~ph_m;

  // CPU bus: read data valid one cycle after the strobe, garbage otherwise.
  always @(posedge clk) mem_data_in <= dma_rd ? mem[dma_addr] : 8'($urandom);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_halt"}, {31'd0, cpu_halt}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
    check({tag, "_we"},   {31'd0, oam_we}, 0);
    check({tag, "_rd"},   {31'd0, dma_rd}, 0);
    check({tag, "_addr"}, {16'd0, dma_addr}, 0);
  endtask

  // align: 0 = trigger so ph=0 at T+2, 1 = ph=1 at T+2, 2 = trigger immediately.
  // retrig_at: halted-cycle index at which a page-$07 write is attempted (0 = never).
  // rst_at: assert reset during this WRITE number (0 = never).
  // end_trig: attempt a trigger during the final WRITE.
  task automatic run_xfer(input logic [7:0] page, input logic [7:0] base, input int align,
                          input int retrig_at, input int rst_at, input bit end_trig);
    int exp_halt, cyc, halt, rd_cnt, we_cnt, dead, bad_page, bad_oam;
    if (align != 2) begin
      for (int g = 0; g < 4 && ph_m != align[0]; g++) @(negedge clk);
    end
    for (int i = 0; i < 256; i++) oam_obs[i] = ~mem[{page, 8'(i - int'(base))}];
    reg_we   = 1'b1;
    reg_data = page;
    oam_base = base;
    @(negedge clk);
    reg_we   = 1'b0;
    reg_data = 8'($urandom);
    oam_base = 8'($urandom);
    exp_halt = ph_m ? 513 : 514;
    cyc = 0; halt = 0; rd_cnt = 0; we_cnt = 0; dead = 0; bad_page = 0;
    while (cpu_halt === 1'b1 && cyc < 600) begin
      cyc++;
      halt++;
      reg_we = 1'b0;
      check("busy_eq_halt", {31'd0, busy}, 1);
      check("rd_we_excl", {31'd0, dma_rd & oam_we}, 0);
      if (dma_rd) begin
        check("rd_addr", {16'd0, dma_addr}, {16'd0, page, 8'(rd_cnt)});
        if (rd_cnt == 0) first_addr = dma_addr;
        last_addr = dma_addr;
        if (dma_addr[15:8] == 8'h07 && page != 8'h07) bad_page++;
        rd_cnt++;
      end else begin
        check("addr_quiet", {16'd0, dma_addr}, 0);
      end
      if (oam_we) begin
        check("oam_addr", {24'd0, oam_addr}, {24'd0, 8'(int'(base) + we_cnt)});
        check("oam_data", {24'd0, oam_data}, {24'd0, mem[{page, 8'(we_cnt)}]});
        oam_obs[oam_addr] = oam_data;
        last_waddr = oam_addr;
        we_cnt++;
      end else begin
        check("oam_quiet", {16'd0, oam_addr, oam_data}, 0);
      end
      if (!dma_rd && !oam_we) dead++;
      if (cyc == retrig_at) begin
        reg_we   = 1'b1;
        reg_data = 8'h07;
        oam_base = 8'h55;
      end
      if (end_trig && oam_we && we_cnt == 256) begin
        reg_we   = 1'b1;
        reg_data = 8'h07;
      end
      if (rst_at > 0 && oam_we && we_cnt == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("post_reset");
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("post_reset_no_we", {31'd0, oam_we | cpu_halt}, 0);
        end
        return;
      end
      @(negedge clk);
    end
    check("timeout", {31'd0, cpu_halt === 1'b1}, 0);
    check("halt_cycles", halt, exp_halt);
    check("dead_cycles", dead, exp_halt - 512);
    check("rd_count", rd_cnt, 256);
    check("we_count", we_cnt, 256);
    check("first_addr", {16'd0, first_addr}, {16'd0, page, 8'h00});
    check("last_addr", {16'd0, last_addr}, {16'd0, page, 8'hFF});
    check("last_waddr", {24'd0, last_waddr}, {24'd0, 8'(base - 8'd1)});
    check("stray_page", bad_page, 0);
    bad_oam = 0;
    for (int i = 0; i < 256; i++)
      if (oam_obs[8'(int'(base) + i)] !== mem[{page, 8'(i)}]) bad_oam++;
    check("oam_image", bad_oam, 0);
    check_idle_outputs("first_idle");
    if (end_trig) begin
      reg_we = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check("end_trig_ignored", {31'd0, cpu_halt}, 0);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    reg_we   = 1'b0;
    reg_data = 8'h00;
    oam_base = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

    repeat (3) @(negedge clk);
    check_idle_outputs("in_reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("after_reset");

    run_xfer(8'h02, 8'h00, 0, 0, 0, 1'b0);
    // Trigger in the very first idle cycle after the previous transfer.
    run_xfer(8'h02, 8'h00, 2, 0, 0, 1'b0);
    run_xfer(8'h02, 8'h00, 1, 0, 0, 1'b0);

    run_xfer(8'h03, 8'hF8, 0, 0, 0, 1'b0);
    check("wrap_0300", {24'd0, oam_obs[8'hF8]}, {24'd0, mem[16'h0300]});
    check("wrap_0308", {24'd0, oam_obs[8'h00]}, {24'd0, mem[16'h0308]});

    run_xfer(8'h02, 8'h10, 1, 100, 0, 1'b0);
    run_xfer(8'h02, 8'h00, 0, 0, 40, 1'b0);
    run_xfer(8'h02, 8'h00, 1, 0, 0, 1'b0);
    run_xfer(8'hFF, 8'h80, 0, 0, 0, 1'b1);

    for (int n = 0; n < 5; n++)
      run_xfer(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
               (n == 2) ? int'($urandom_range(3, 500)) : 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
